// File: rtl/fan_row_accumulator_pkg.sv
// Shared lane layout and state encoding for the fan adder output path.
package fan_row_accumulator_pkg;

  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Lane layout: data at the bottom, row index above it, ctrl on top.
  function automatic int unsigned data_lsb();
    return 0;
  endfunction

  function automatic int unsigned row_lsb(input int unsigned dw_data);
    return dw_data;
  endfunction

  function automatic int unsigned ctrl_lsb(input int unsigned dw_data, input int unsigned dw_row);
    return dw_data + dw_row;
  endfunction

  // A lane carries a live value when either of the two top ctrl bits is set
  // (adder result or kept bypass line).
  function automatic int unsigned live_hi_bit(input int unsigned dw_ctrl);
    return dw_ctrl - 1;
  endfunction

  function automatic int unsigned live_lo_bit(input int unsigned dw_ctrl);
    return dw_ctrl - 2;
  endfunction

endpackage

// File: rtl/fan_row_lane_sum.sv
// Combinational per-row reduction of one beat: sums the data of every live
// lane into its row bucket and flags which rows were hit.
module fan_row_lane_sum
  import fan_row_accumulator_pkg::*;
#(
  parameter int unsigned DW_DATA = 8,
  parameter int unsigned DW_ROW  = 4,
  parameter int unsigned DW_CTRL = 4,
  parameter int unsigned DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned NUM_ROW = 1 << DW_ROW,
  parameter int unsigned DW_ACC  = 16
) (
  input  logic [NUM_IN*DW_LINE-1:0]         lanes_i,
  output logic [NUM_ROW-1:0][DW_ACC-1:0]    sum_o,
  output logic [NUM_ROW-1:0]                hit_o
);

  localparam int unsigned DATA_LSB = data_lsb();
  localparam int unsigned ROW_LSB  = row_lsb(DW_DATA);
  localparam int unsigned CTRL_LSB = ctrl_lsb(DW_DATA, DW_ROW);
  localparam int unsigned LIVE_HI  = live_hi_bit(DW_CTRL);
  localparam int unsigned LIVE_LO  = live_lo_bit(DW_CTRL);

  // Lower ctrl bits carry no meaning for the accumulator.
  logic unused_lane_bits;
  assign unused_lane_bits = ^lanes_i;

  // Scatter every live lane into its row bucket; lanes sharing a row add up.
  always_comb begin
    sum_o = '0;
    hit_o = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (lanes_i[i*DW_LINE + CTRL_LSB + LIVE_HI] || lanes_i[i*DW_LINE + CTRL_LSB + LIVE_LO]) begin
        sum_o[lanes_i[i*DW_LINE + ROW_LSB +: DW_ROW]] =
          sum_o[lanes_i[i*DW_LINE + ROW_LSB +: DW_ROW]]
          + DW_ACC'(lanes_i[i*DW_LINE + DATA_LSB +: DW_DATA]);
        hit_o[lanes_i[i*DW_LINE + ROW_LSB +: DW_ROW]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fan_row_accumulator.sv
// Per-row accumulator bank behind the last fan adder stage. Accumulates live
// lanes for one tile, then drains touched rows in ascending order.
module fan_row_accumulator
  import fan_row_accumulator_pkg::*;
#(
  parameter int unsigned DW_DATA = 8,
  parameter int unsigned DW_ROW  = 4,
  parameter int unsigned DW_CTRL = 4,
  parameter int unsigned DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned NUM_ROW = 1 << DW_ROW,
  parameter int unsigned DW_ACC  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*DW_LINE-1:0] in,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW_ROW-1:0]         out_row,
  output logic [DW_ACC-1:0]         out_data,
  output logic                      tile_done
);

  state_e                         state_q, state_d;
  logic [NUM_ROW-1:0][DW_ACC-1:0] acc_q, acc_d;
  logic [NUM_ROW-1:0]             touched_q, touched_d;
  logic                           tile_done_q, tile_done_d;

  logic [NUM_ROW-1:0][DW_ACC-1:0] beat_sum;
  logic [NUM_ROW-1:0]             beat_hit;
  logic [DW_ROW-1:0]              sel_row;
  logic                           sel_found;
  logic                           accept;
  logic                           drain_hs;

  fan_row_lane_sum #(
    .DW_DATA (DW_DATA),
    .DW_ROW  (DW_ROW),
    .DW_CTRL (DW_CTRL),
    .DW_LINE (DW_LINE),
    .NUM_IN  (NUM_IN),
    .NUM_ROW (NUM_ROW),
    .DW_ACC  (DW_ACC)
  ) u_lane_sum (
    .lanes_i (in),
    .sum_o   (beat_sum),
    .hit_o   (beat_hit)
  );

  // Lowest touched row is the next one to drain.
  always_comb begin
    sel_row   = '0;
    sel_found = 1'b0;
    for (int unsigned r = 0; r < NUM_ROW; r++) begin
      if (touched_q[r] && !sel_found) begin
        sel_row   = DW_ROW'(r);
        sel_found = 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DRAIN) && sel_found;
  assign out_row   = (state_q == ST_DRAIN) ? sel_row : '0;
  assign out_data  = out_valid ? acc_q[sel_row] : '0;
  assign drain_hs  = out_valid && out_ready;
  assign tile_done = tile_done_q;

  // Next-state: accumulate beats in ACC, retire one row per handshake in DRAIN.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    touched_d   = touched_q;
    tile_done_d = 1'b0;
    unique case (state_q)
      ST_ACC: begin
        if (accept) begin
          for (int unsigned r = 0; r < NUM_ROW; r++) begin
            acc_d[r] = acc_q[r] + beat_sum[r];
          end
          touched_d = touched_q | beat_hit;
          if (in_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_hs) begin
          touched_d[sel_row] = 1'b0;
          acc_d[sel_row]     = '0;
        end
        // Leaving as soon as the bitmap empties also covers an empty tile,
        // which therefore spends a single cycle in DRAIN.
        if (touched_d == '0) begin
          state_d     = ST_ACC;
          tile_done_d = 1'b1;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      touched_q   <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      touched_q   <= touched_d;
      tile_done_q <= tile_done_d;
    end
  end

endmodule
